// File: rtl/quad_dec_pkg.sv
// ============================================================================
//  Module   : quad_dec_pkg
//  Purpose  : Shared state codes and the transition classifier for the
//             quadrature step decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package quad_dec_pkg;

    // Channel pair encoded as {A,B}; the up direction walks S00->S10->S11->S01.
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    typedef struct packed {
        logic valid;
        logic illegal;
        logic dir;
    } dec_t;

    function automatic dec_t next_dir(input logic [1:0] prev, input logic [1:0] cur);
        dec_t       r;
        logic [1:0] fwd;
        r = '0;
        case (prev)
            S00:     fwd = S10;
            S10:     fwd = S11;
            S11:     fwd = S01;
            default: fwd = S00;
        endcase
        if (cur == prev) begin
            r = '0;
        end else if (cur == ~prev) begin
            r.illegal = 1'b1;
        end else begin
            r.valid = 1'b1;
            r.dir   = (cur == fwd);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quad_glitch_filter.sv
// ============================================================================
//  Module   : quad_glitch_filter
//  Purpose  : Two-flop synchroniser followed by a persistence filter; the
//             output level follows the input only after FILT disagreeing samples.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_glitch_filter #(
    parameter int FILT = 2
) (
    input  logic C,
    input  logic CLR,
    input  logic raw,
    output logic level
);

    localparam int             CW   = (FILT < 2) ? 1 : $clog2(FILT);
    localparam logic [CW-1:0]  LAST = CW'(FILT - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreeing sample restarts the persistence count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/quadrature_step_decoder.sv
// ============================================================================
//  Module   : quadrature_step_decoder
//  Purpose  : Quadrature A/B decoder producing step pulses, direction, a
//             wrapping position count and a sticky illegal-transition flag.
//             Define QUAD_INDEX_EN to add the IDX input that zeroes Q.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quadrature_step_decoder
    import quad_dec_pkg::*;
#(
    parameter int W    = 16,
    parameter int FILT = 2
) (
    input  logic         C,
    input  logic         CLR,
    input  logic         A,
    input  logic         B,
    input  logic         cnt_en,
    input  logic         err_clr,
`ifdef QUAD_INDEX_EN
    input  logic         IDX,
`endif
    output logic         step,
    output logic         up_down,
    output logic [W-1:0] Q,
    output logic         err
);

    logic         a_f;
    logic         b_f;
    logic [1:0]   filt_ab;
    logic [1:0]   state;
    logic         init;
    dec_t         dec;
    logic         changed;
    logic         do_step;
    logic         do_err;
    logic [W-1:0] q_next;

    quad_glitch_filter #(.FILT(FILT)) u_filt_a (
        .C     (C),
        .CLR   (CLR),
        .raw   (A),
        .level (a_f)
    );

    quad_glitch_filter #(.FILT(FILT)) u_filt_b (
        .C     (C),
        .CLR   (CLR),
        .raw   (B),
        .level (b_f)
    );

    assign filt_ab = {a_f, b_f};

`ifdef QUAD_INDEX_EN
    logic idx_s1;
    logic idx_s2;
    logic idx_s3;
    logic idx_rise;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            idx_s1 <= 1'b0;
            idx_s2 <= 1'b0;
            idx_s3 <= 1'b0;
        end else begin
            idx_s1 <= IDX;
            idx_s2 <= idx_s1;
            idx_s3 <= idx_s2;
        end
    end

    assign idx_rise = idx_s2 & ~idx_s3;
`endif

    always_comb begin
        dec     = next_dir(state, filt_ab);
        changed = (filt_ab != state);
        // The first filtered update after reset only aligns the state register.
        do_step = changed && !init && dec.valid && cnt_en;
        do_err  = changed && !init && dec.illegal;
        q_next  = Q;
        if (do_step) begin
            q_next = dec.dir ? (Q + W'(1)) : (Q - W'(1));
        end
`ifdef QUAD_INDEX_EN
        if (idx_rise) begin
            q_next = '0;
        end
`endif
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state   <= S00;
            init    <= 1'b1;
            step    <= 1'b0;
            up_down <= 1'b1;
            Q       <= '0;
            err     <= 1'b0;
        end else begin
            step <= do_step;
            Q    <= q_next;
            if (changed) begin
                state <= filt_ab;
                init  <= 1'b0;
            end
            if (do_step) begin
                up_down <= dec.dir;
            end
            if (do_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quadrature_step_decoder.sv
// ============================================================================
//  Module   : tb_quadrature_step_decoder
//  Purpose  : Randomised scoreboard bench for quadrature_step_decoder with a
//             phase-arithmetic reference model. Honours QUAD_INDEX_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quadrature_step_decoder;

    localparam int W    = 16;
    localparam int FILT = 2;
    localparam int LAT  = FILT + 3;
    localparam int HOLD = 10;

    logic         C = 1'b0;
    logic         CLR;
    logic         A;
    logic         B;
    logic         cnt_en;
    logic         err_clr;
    logic         step;
    logic         up_down;
    logic [W-1:0] Q;
    logic         err;
`ifdef QUAD_INDEX_EN
    logic         IDX;
`endif

    quadrature_step_decoder #(.W(W), .FILT(FILT)) dut (
        .C       (C),
        .CLR     (CLR),
        .A       (A),
        .B       (B),
        .cnt_en  (cnt_en),
        .err_clr (err_clr),
`ifdef QUAD_INDEX_EN
        .IDX     (IDX),
`endif
        .step    (step),
        .up_down (up_down),
        .Q       (Q),
        .err     (err)
    );

    always #5 C = ~C;

    int cyc = 0;
    always @(posedge C) cyc <= cyc + 1;

    typedef struct {
        int           due;
        bit           stp;
        bit           up;
        logic [W-1:0] q;
        bit           er;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: encoder phase as an angle 0..3, count as modular arithmetic.
    int           m_pos;
    bit           m_init;
    logic [W-1:0] m_q;
    bit           m_up;
    bit           m_err;
    int           cur_p;

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (((p % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_init = 1;
        m_q    = '0;
        m_up   = 1;
        m_err  = 0;
    endtask

    task automatic model_update(input logic [1:0] ab);
        int   np;
        int   d;
        exp_t e;
        np = pos_of(ab);
        if (np == m_pos) return;
        if (m_init) begin
            m_init = 0;
            m_pos  = np;
            return;
        end
        d     = (np - m_pos + 4) % 4;
        m_pos = np;
        e.stp = 0;
        if (d == 2) begin
            m_err = 1;
        end else if (cnt_en) begin
            e.stp = 1;
            m_up  = (d == 1);
            m_q   = (d == 1) ? m_q + W'(1) : m_q - W'(1);
        end
        e.due = cyc + LAT;
        e.up  = m_up;
        e.q   = m_q;
        e.er  = m_err;
        sb.push_back(e);
    endtask

    task automatic settled_check();
        chk("settled_q", 32'(Q), 32'(m_q));
        chk("settled_up_down", 32'(up_down), 32'(m_up));
        chk("settled_err", 32'(err), 32'(m_err));
    endtask

    task automatic drive(input int p, input bit en, input bit clr_err);
        @(posedge C); #2;
        cnt_en = en;
        {A, B} = ab_of(p);
        cur_p  = ((p % 4) + 4) % 4;
        if (clr_err) begin
            err_clr = 1'b1;
            m_err   = 0;
        end
        model_update(ab_of(p));
        @(posedge C); #2;
        err_clr = 1'b0;
        repeat (HOLD - 2) @(posedge C);
        #2;
        settled_check();
    endtask

    task automatic glitch_a();
        @(posedge C); #2;
        A = ~A;
        @(posedge C); #2;
        A = ~A;
        repeat (HOLD - 2) @(posedge C);
        #2;
        settled_check();
    endtask

    // Monitor: pops the expectation that falls due on this cycle.
    always @(negedge C) begin : mon
        exp_t e;
        bit   es;
        if (!CLR) begin
            es = 0;
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("sb_late_entry", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e  = sb.pop_front();
                es = e.stp;
                chk("sb_q", 32'(Q), 32'(e.q));
                chk("sb_up_down", 32'(up_down), 32'(e.up));
                chk("sb_err", 32'(err), 32'(e.er));
            end
            chk("sb_step", 32'(step), 32'(es));
        end
    end

    initial begin
        int r;
        CLR     = 1'b1;
        A       = 1'b1;
        B       = 1'b1;
        cnt_en  = 1'b1;
        err_clr = 1'b0;
`ifdef QUAD_INDEX_EN
        IDX     = 1'b0;
`endif
        cur_p = 2;
        model_reset();
        repeat (3) @(posedge C);
        #2;
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_up_down", 32'(up_down), 32'h1);
        chk("rst_step", 32'(step), 32'h0);
        CLR = 1'b0;
        model_update(ab_of(cur_p));
        repeat (20) @(posedge C);
        #2;
        settled_check();

        // Up through a full cycle and a half, then back down.
        for (int i = 1; i <= 6; i++) drive(2 + i, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) drive(cur_p - 1, 1'b1, 1'b0);

        // Short glitch is rejected; a double transition sets err.
        glitch_a();
        drive(cur_p + 2, 1'b1, 1'b0);
        chk("illegal_err", 32'(err), 32'h1);
        @(posedge C); #2;
        err_clr = 1'b1;
        m_err   = 0;
        @(posedge C); #2;
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'h0);

        // Disabled counting still tracks position; re-enable is silent.
        for (int i = 1; i <= 3; i++) drive(cur_p + 1, 1'b0, 1'b0);
        @(posedge C); #2;
        cnt_en = 1'b1;
        repeat (20) @(posedge C);
        #2;
        settled_check();

`ifdef QUAD_INDEX_EN
        // Index pulse timed to land on the same edge as an up step.
        @(posedge C); #2;
        cur_p  = (cur_p + 1) % 4;
        {A, B} = ab_of(cur_p);
        model_update(ab_of(cur_p));
        m_q       = '0;
        sb[$].q   = '0;
        repeat (FILT) @(posedge C);
        #2;
        IDX = 1'b1;
        repeat (6) @(posedge C);
        #2;
        IDX = 1'b0;
        settled_check();
        chk("idx_q_zero", 32'(Q), 32'h0);
`endif

        // Reset in the middle of an in-flight transition.
        @(posedge C); #2;
        cur_p  = (cur_p + 1) % 4;
        {A, B} = ab_of(cur_p);
        model_update(ab_of(cur_p));
        repeat (2) @(posedge C);
        @(negedge C); #1;
        CLR = 1'b1;
        #1;
        chk("midrst_q", 32'(Q), 32'h0);
        chk("midrst_step", 32'(step), 32'h0);
        chk("midrst_up_down", 32'(up_down), 32'h1);
        chk("midrst_err", 32'(err), 32'h0);
        sb.delete();
        model_reset();
        repeat (2) @(posedge C);
        #2;
        CLR = 1'b0;
        model_update(ab_of(cur_p));
        repeat (HOLD) @(posedge C);

        // Downward wrap from zero.
        drive(cur_p - 1, 1'b1, 1'b0);
        chk("wrap_first", 32'(Q), 32'hFFFF);
        for (int i = 0; i < 3; i++) drive(cur_p - 1, 1'b1, 1'b0);
        chk("wrap_fourth", 32'(Q), 32'hFFFC);
        chk("wrap_up_down", 32'(up_down), 32'h0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      drive(cur_p + 1, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0);
            else if (r < 70) drive(cur_p + 3, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0);
            else if (r < 80) drive(cur_p + 2, 1'b1, $urandom_range(0, 3) == 0);
            else             glitch_a();
        end

        repeat (HOLD) @(posedge C);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
